// File: rtl/sa_pkg.sv
// Shared types and constants for the weight-stationary array feeder.
package sa_pkg;

  localparam int unsigned SA_N         = 4;
  localparam int unsigned SA_DW        = 8;
  localparam int unsigned DRAIN_CYCLES = 2 * SA_N + 1;

  typedef enum logic [2:0] {
    StIdle,
    StAcceptW,
    StLoadW,
    StStream,
    StDrain
  } sa_state_e;

  // Cycles from the final accept until the last column marker leaves the array.
  function automatic int unsigned drain_cycles(input int unsigned n);
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/sa_feeder_if.sv
// Host-side weight and input-vector streams into the feeder.
interface sa_feeder_if import sa_pkg::*; #(
  parameter int unsigned N  = SA_N,
  parameter int unsigned DW = SA_DW
) ();

  logic            w_valid;
  logic            w_ready;
  logic [N*DW-1:0] w_data;
  logic            x_valid;
  logic            x_ready;
  logic [N*DW-1:0] x_data;
  logic            x_last;

  modport master (
    output w_valid, w_data, x_valid, x_data, x_last,
    input  w_ready, x_ready
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data, x_last,
    output w_ready, x_ready
  );

endinterface

// File: rtl/sa_skew_line.sv
// Depth-D register chain carrying {valid, data}; D = 0 is a plain wire.
module sa_skew_line import sa_pkg::*; #(
  parameter int unsigned D = 1,
  parameter int unsigned W = SA_DW
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  if (D == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RSTN;
    assign valid_o = valid_i;
    assign data_o  = data_i;
  end else begin : g_chain
    logic [D-1:0][W:0] stage_q, stage_d;

    always_comb begin
      stage_d[0] = {valid_i, data_i};
      for (int unsigned i = 1; i < D; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign {valid_o, data_o} = stage_q[D-1];
  end

endmodule

// File: rtl/sa_feeder.sv
// Feeder for an NxN weight-stationary MAC array: buffers and shifts in one weight tile,
// then skews the input-vector stream onto the array edge with per-row/column markers.
module sa_feeder import sa_pkg::*; #(
  parameter int unsigned N  = SA_N,
  parameter int unsigned DW = SA_DW
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   start,
  input  logic [$clog2(N+1)-1:0] num_rows,
  output logic                   busy,
  output logic                   done,
  sa_feeder_if.slave             host,
  output logic                   sa_en_w,
  output logic [N*DW-1:0]        sa_w,
  output logic [N-1:0]           sa_used_row,
  output logic [N-1:0]           sa_stop_mac,
  output logic [N*DW-1:0]        sa_x,
  output logic [N-1:0]           sa_col_valid
);

  localparam int unsigned NrW         = $clog2(N + 1);
  localparam int unsigned RowW        = $clog2(N);
  localparam int unsigned DrainCycles = drain_cycles(N);
  localparam int unsigned CntW        = $clog2(DrainCycles);

  sa_state_e              state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [N-1:0][N*DW-1:0] tile_q, tile_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   w_ready_q, w_ready_d, x_ready_q, x_ready_d, en_w_q, en_w_d;
  logic [N*DW-1:0]        w_q, w_d;
  logic [N-1:0]           used_q, used_d;
  logic [NrW-1:0]         rows_clamped;
  logic [N-1:0]           row_mask;
  logic [RowW-1:0]        load_idx;
  logic                   w_acc, x_acc;

  assign w_acc        = w_ready_q & host.w_valid;
  assign x_acc        = x_ready_q & host.x_valid;
  assign rows_clamped = (num_rows > NrW'(N)) ? NrW'(N) : num_rows;
  // Cycle j of the load shifts in tile row N-1-j; this is the row for the following cycle.
  assign load_idx     = RowW'(N - 2) - cnt_q[RowW-1:0];

  always_comb begin
    row_mask = '0;
    for (int unsigned r = 0; r < N; r++) begin
      row_mask[r] = (NrW'(r) < rows_clamped);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tile_d  = tile_q;
    used_d  = used_q;
    done_d  = 1'b0;
    w_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StAcceptW;
          cnt_d   = '0;
          used_d  = row_mask;
        end
      end
      StAcceptW: begin
        if (w_acc) begin
          tile_d[cnt_q[RowW-1:0]] = host.w_data;
          if (cnt_q == CntW'(N - 1)) begin
            state_d = StLoadW;
            cnt_d   = '0;
            w_d     = host.w_data;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLoadW: begin
        if (cnt_q == CntW'(N - 1)) begin
          state_d = StStream;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          w_d   = tile_q[load_idx];
        end
      end
      StStream: begin
        if (x_acc && host.x_last) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (cnt_q == CntW'(DrainCycles - 1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          used_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d    = (state_d != StIdle);
    w_ready_d = (state_d == StAcceptW);
    x_ready_d = (state_d == StStream);
    en_w_d    = (state_d == StLoadW);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_ready_q <= 1'b0;
      x_ready_q <= 1'b0;
      en_w_q    <= 1'b0;
      w_q       <= '0;
      used_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_ready_q <= w_ready_d;
      x_ready_q <= x_ready_d;
      en_w_q    <= en_w_d;
      w_q       <= w_d;
      used_q    <= used_d;
    end
  end

  always_ff @(posedge CLK) begin
    tile_q <= tile_d;
  end

  // Input skew: accept register, r-stage delay for row r, then output register.
  logic                   acc_v_q, acc_v_d, last_v_q, last_v_d;
  logic [N*DW-1:0]        acc_x_q, acc_x_d;
  logic [N-1:0]           sk_v;
  logic [N-1:0][DW-1:0]   sk_x, x_q, x_d;
  logic [N-1:0]           col_q, col_d;

  always_comb begin
    acc_v_d  = x_acc;
    acc_x_d  = x_acc ? host.x_data : '0;
    x_d      = sk_x;
    last_v_d = sk_v[N-1];
    col_d    = {col_q[N-2:0], last_v_q};
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    sa_skew_line #(
      .D(r),
      .W(DW)
    ) u_skew (
      .CLK    (CLK),
      .RSTN   (RSTN),
      .valid_i(acc_v_q),
      .data_i (acc_x_q[r*DW +: DW]),
      .valid_o(sk_v[r]),
      .data_o (sk_x[r])
    );
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      acc_v_q  <= 1'b0;
      acc_x_q  <= '0;
      x_q      <= '0;
      last_v_q <= 1'b0;
      col_q    <= '0;
    end else begin
      acc_v_q  <= acc_v_d;
      acc_x_q  <= acc_x_d;
      x_q      <= x_d;
      last_v_q <= last_v_d;
      col_q    <= col_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign host.w_ready = w_ready_q;
  assign host.x_ready = x_ready_q;
  assign sa_en_w      = en_w_q;
  assign sa_w         = w_q;
  assign sa_used_row  = used_q;
  assign sa_stop_mac  = ~sk_v;
  assign sa_x         = x_q;
  assign sa_col_valid = col_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Bench for sa_feeder: directed job sequence with random data, checked every cycle against
// an event-timestamp model of the feeder's externally visible behaviour.
module tb_sa_feeder;
  import sa_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int NW   = N * DW;
  localparam int MAXC = 1024;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          start;
  logic [2:0]    num_rows;
  logic          busy, done, sa_en_w;
  logic [NW-1:0] sa_w, sa_x;
  logic [N-1:0]  sa_used_row, sa_stop_mac, sa_col_valid;

  sa_feeder_if #(.N(N), .DW(DW)) bus ();

  sa_feeder #(.N(N), .DW(DW)) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .start       (start),
    .num_rows    (num_rows),
    .busy        (busy),
    .done        (done),
    .host        (bus),
    .sa_en_w     (sa_en_w),
    .sa_w        (sa_w),
    .sa_used_row (sa_used_row),
    .sa_stop_mac (sa_stop_mac),
    .sa_x        (sa_x),
    .sa_col_valid(sa_col_valid)
  );

  always #5 CLK = ~CLK;

  // Model: each job is described by the cycles of its key events.
  int            cyc, n_pass, n_total;
  bit            acc_v [MAXC];
  logic [NW-1:0] acc_d [MAXC];
  logic [NW-1:0] tile_m [N];
  bit            have_job;
  int            t_start, t_wlast, t_xlast, done_at, beats, nr_m;

  function automatic void model_reset();
    for (int i = 0; i < MAXC; i++) acc_v[i] = 1'b0;
    have_job = 1'b0;
    t_start  = -1;
    t_wlast  = -1;
    t_xlast  = -1;
    done_at  = -1;
    beats    = 0;
    nr_m     = 0;
  endfunction

  function automatic bit busy_m(input int t);
    return have_job && t > t_start && (t_xlast < 0 || t < t_xlast + 2 * N + 2);
  endfunction

  function automatic bit w_ready_m(input int t);
    return have_job && t > t_start && beats < N;
  endfunction

  function automatic bit en_w_m(input int t);
    return have_job && t_wlast >= 0 && t > t_wlast && t <= t_wlast + N;
  endfunction

  function automatic bit x_ready_m(input int t);
    return have_job && t_wlast >= 0 && t > t_wlast + N && (t_xlast < 0 || t <= t_xlast);
  endfunction

  function automatic bit acc_at(input int t);
    return t >= 0 && t < MAXC && acc_v[t];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Check all outputs for the current cycle, apply this cycle's handshakes, advance.
  task automatic tick();
    logic [NW-1:0] ex_x, ex_w;
    logic [N-1:0]  ex_stop, ex_col, ex_used;
    int            s;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    @(negedge CLK);
    ex_x    = '0;
    ex_stop = '1;
    ex_col  = '0;
    ex_used = '0;
    for (int r = 0; r < N; r++) begin
      s = cyc - 2 - r;
      if (acc_at(s)) ex_x[r*DW +: DW] = acc_d[s][r*DW +: DW];
      if (acc_at(cyc - 1 - r)) ex_stop[r] = 1'b0;
      if (acc_at(cyc - N - 2 - r)) ex_col[r] = 1'b1;
      if (busy_m(cyc) && r < nr_m) ex_used[r] = 1'b1;
    end
    ex_w = en_w_m(cyc) ? tile_m[N + t_wlast - cyc] : '0;
    chk("busy", busy, busy_m(cyc));
    chk("done", done, done_at == cyc);
    chk("w_ready", bus.w_ready, w_ready_m(cyc));
    chk("x_ready", bus.x_ready, x_ready_m(cyc));
    chk("sa_en_w", sa_en_w, en_w_m(cyc));
    chk("sa_w", sa_w, ex_w);
    chk("sa_used_row", sa_used_row, ex_used);
    chk("sa_stop_mac", sa_stop_mac, ex_stop);
    chk("sa_x", sa_x, ex_x);
    chk("sa_col_valid", sa_col_valid, ex_col);
    if (RSTN) begin
      if (w_ready_m(cyc) && bus.w_valid) begin
        tile_m[beats] = bus.w_data;
        beats++;
        if (beats == N) t_wlast = cyc;
      end
      if (x_ready_m(cyc) && bus.x_valid) begin
        acc_v[cyc] = 1'b1;
        acc_d[cyc] = bus.x_data;
        if (bus.x_last) begin
          t_xlast = cyc;
          done_at = cyc + 2 * N + 2;
        end
      end
      if (!busy_m(cyc) && start) begin
        have_job = 1'b1;
        t_start  = cyc;
        beats    = 0;
        t_wlast  = -1;
        t_xlast  = -1;
        nr_m     = (int'(num_rows) > N) ? N : int'(num_rows);
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic send_vec(input logic [NW-1:0] d, input bit last);
    bus.x_valid = 1'b1;
    bus.x_data  = d;
    bus.x_last  = last;
    tick();
    bus.x_valid = 1'b0;
    bus.x_last  = 1'b0;
  endtask

  task automatic begin_job(input logic [2:0] nr);
    num_rows = nr;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic load_random_tile();
    for (int k = 0; k < N; k++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = $urandom;
      tick();
    end
    bus.w_valid = 1'b0;
    repeat (N) tick();
  endtask

  initial begin
    RSTN        = 1'b1;
    start       = 1'b0;
    num_rows    = '0;
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
    bus.x_valid = 1'b0;
    bus.x_data  = '0;
    bus.x_last  = 1'b0;
    cyc         = 0;
    n_pass      = 0;
    n_total     = 0;
    model_reset();
    #1 RSTN = 1'b0;
    tick();
    tick();
    RSTN = 1'b1;
    tick();

    // Identity weights, three back-to-back vectors.
    begin_job(3'd4);
    for (int k = 0; k < N; k++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = NW'(1) << (k * DW);
      tick();
    end
    bus.w_valid = 1'b0;
    repeat (N) tick();
    send_vec(32'h04030201, 1'b0);
    send_vec(32'h08070605, 1'b0);
    send_vec(32'hFCFDFEFF, 1'b1);
    repeat (2 * N + 4) tick();

    // Weight beats with gaps, start pulsed while busy, two-cycle bubble mid-stream.
    begin_job(3'd2);
    for (int i = 0; i < 10; i++) begin
      bus.w_valid = (i == 0 || i == 3 || i == 4 || i == 9);
      bus.w_data  = $urandom;
      start       = (i == 5);
      tick();
    end
    bus.w_valid = 1'b0;
    start       = 1'b0;
    repeat (N) tick();
    for (int v = 0; v < 8; v++) begin
      if (v == 3) begin
        bus.x_data = $urandom;
        repeat (2) tick();
      end
      send_vec($urandom, v == 7);
    end
    repeat (2 * N + 4) tick();

    // Clamped row count; x_valid/x_last offered during the load; random valid pattern.
    begin_job(3'd7);
    for (int k = 0; k < N; k++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = $urandom;
      bus.x_valid = 1'b1;
      bus.x_data  = $urandom;
      tick();
    end
    bus.w_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      bus.x_valid = 1'b1;
      bus.x_data  = $urandom;
      bus.x_last  = (j == N - 1);
      tick();
    end
    bus.x_last = 1'b0;
    for (int v = 0; v < 12; v++) begin
      bus.x_valid = 1'($urandom_range(0, 1));
      bus.x_data  = $urandom;
      start       = 1'($urandom_range(0, 1));
      tick();
    end
    send_vec($urandom, 1'b1);
    start = 1'b0;
    for (int d = 0; d < 2 * N + 4; d++) begin
      bus.x_valid = 1'($urandom_range(0, 1));
      bus.x_data  = $urandom;
      tick();
    end
    bus.x_valid = 1'b0;

    // Reset during streaming, then a fresh job with zero active rows.
    begin_job(3'd3);
    load_random_tile();
    for (int v = 0; v < 3; v++) send_vec($urandom, 1'b0);
    RSTN = 1'b0;
    model_reset();
    tick();
    tick();
    RSTN = 1'b1;
    tick();
    begin_job(3'd0);
    load_random_tile();
    for (int v = 0; v < 4; v++) send_vec($urandom, v == 3);
    repeat (2 * N + 4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Host-side driver for the NxN weight-stationary MAC array; the transmitting end of the PE interface.
- Buffers one weight tile and shifts it into the array top with en_w.
- Skews the input-vector stream onto the array's left edge, generates per-row used_row/stop_mac, and emits per-column valid markers aligned to the array-bottom partial sums.

Parameters:
N, 4, array dimension (rows = columns)
DW, 8, element width (signed)

Ports:
CLK  in  1  clock
RSTN  in  1  asynchronous, active-low reset
start  in  1  begin job; ignored unless IDLE
num_rows  in  $clog2(N+1)  active rows, sampled at start; values >N clamp to N
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
w_valid  in  1  weight beat valid
w_ready  out  1  high only in ACCEPT_W
w_data  in  N*DW  beat k = array row k; element c = column c
x_valid  in  1  input vector valid
x_ready  out  1  high only in STREAM
x_data  in  N*DW  element r feeds array row r
x_last  in  1  marks final vector
sa_en_w  out  1  broadcast weight-load enable
sa_w  out  N*DW  weight into top of column c
sa_used_row  out  N  bit r = (r < num_rows)
sa_stop_mac  out  N  per-row MAC suppress, row-0 PE input
sa_x  out  N*DW  input into left of row r
sa_col_valid  out  N  bit c marks a real result at column-c bottom

Behaviour:
- All outputs registered.
- Reset and RSTN mid-job force IDLE. Reset values: busy/done/w_ready/x_ready/sa_en_w/sa_col_valid = 0; sa_w/sa_x = 0; sa_used_row = 0; sa_stop_mac = all 1s. Tile buffer contents don't-care.
- FSM states: IDLE, ACCEPT_W, LOAD_W, STREAM, DRAIN.
- IDLE -> ACCEPT_W on start; latch clamped num_rows.
- ACCEPT_W:
  - w_ready = 1; each w_valid beat written to tile row = beat counter.
  - After beat N-1 -> LOAD_W.
  - No array activity; stalls indefinitely on w_valid low.
- LOAD_W:
  - Exactly N cycles, sa_en_w = 1; cycle j drives sa_w = tile row N-1-j, so row r ends holding tile row r.
  - Never stalls; PE weight chain shifts every cycle.
  - sa_used_row valid throughout; sa_x = 0.
- STREAM:
  - x_ready = 1; feeder never back-pressures.
  - Beat accepted at edge of cycle k: sa_stop_mac[r] = 0 during cycle k+1+r; sa_x[r] = element r during cycle k+2+r; sa_col_valid[c] = 1 during cycle k+N+2+c.
  - x_valid low -> bubble: sa_x[r] = 0 and sa_stop_mac[r] = 1 at the same skewed slots; col_valid stays 0.
  - Accept with x_last -> DRAIN.
- DRAIN:
  - Counter runs until last beat's sa_col_valid[N-1] (cycle k_last+2N+1).
  - done pulses cycle k_last+2N+2; same edge -> IDLE.
- Skew: internal accept register, then a per-row delay line of r stages plus output register. Valid bit travels the same delays.
- sa_stop_mac = 1 whenever no valid beat is scheduled, including IDLE/ACCEPT_W/LOAD_W.
- start while busy ignored; x_valid outside STREAM ignored; w_valid outside ACCEPT_W ignored.
- num_rows = 0: job runs normally; array yields zero sums; col_valid still asserted.

Decomposition:
- Shared package sa_pkg: FSM state enum, DW, default N, localparam DRAIN_CYCLES = 2N+1.
- One sub-module, sa_skew_line: parameterised depth-D register chain for {valid, data}, reset to 0. Instantiated once per row, D = r.

Test Plan:
- N=4, num_rows=4, identity weights, 3 back-to-back vectors [1,2,3,4],[5,6,7,8],[-1,-2,-3,-4] -> sa_x[r] appears 2+r cycles after accept; sa_col_valid[c] high at k+6+c; array outputs equal the inputs; done at k_last+10.
- w_valid gaps in ACCEPT_W (beats at cycles 0,3,4,9) -> sa_en_w stays 0 until all 4 beats received, then exactly 4 contiguous cycles with rows 3,2,1,0 driven in order.
- x_valid low for 2 cycles mid-stream -> matching 2-cycle holes in sa_col_valid per column; sa_stop_mac[r] high in the skewed slots; sa_x zero there.
- num_rows=2 -> sa_used_row = 4'b0011; num_rows=7 -> clamped to 4'b1111.
- RSTN asserted during STREAM -> next cycle all outputs at reset values, busy=0; fresh start completes normally.
- start pulsed while busy, and x_valid during LOAD_W -> both ignored; x_ready=0 in LOAD_W; no extra col_valid.
